// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture: triggered oscilloscope capture into a circular buffer,
// holding one trigger-aligned frame with its min/max/peak-to-peak for readout.
module scope_trigger_capture #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 800,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 100,
    parameter int AUTO_TO  = 65535
) (
    input  logic              CLK_50M,
    input  logic              RST,
    input  logic              AD_CS,
    input  logic [DATA_W-1:0] in_ad_data,
    input  logic              enable,
    input  logic [1:0]        trig_mode,
    input  logic              trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [7:0]        dec_ratio,
    input  logic              arm,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    output logic              frame_done,
    output logic              auto_trig,
    output logic [DATA_W-1:0] samp_max,
    output logic [DATA_W-1:0] samp_min,
    output logic [DATA_W-1:0] pk_pk
);
    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, HOLD} state_t;

    state_t            state_q, state_d;
    logic              ad_s1_q, ad_s2_q, ad_s3_q;
    logic [7:0]        dec_cnt_q, dec_cnt_d, dec_q, dec_d, dec_max;
    logic [1:0]        mode_q, mode_d;
    logic              edge_q, edge_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, rd_base, rd_phys;
    logic [ADDR_W:0]   rd_room;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d, max_q, max_d, min_q, min_d, pk_q, pk_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, scan_v, scan_max, scan_min;
    logic              auto_q, auto_d, done_q, done_d;
    logic              stb, writing, store, hit, force_trig;
    logic [DATA_W-1:0] buf_q [DEPTH];

    assign stb        = ad_s2_q & ~ad_s3_q;
    assign writing    = state_q inside {PRE, ARMED, POST};
    assign store      = enable && writing && stb && dec_cnt_q == 8'd0;
    assign dec_max    = (dec_q > 8'd1) ? dec_q - 8'd1 : 8'd0;
    assign hit        = edge_q ? (prev_q > trig_level && in_ad_data <= trig_level)
                               : (prev_q < trig_level && in_ad_data >= trig_level);
    assign force_trig = mode_q == MODE_AUTO && cnt_q == 32'(AUTO_TO);

    // At HOLD entry the buffer holds exactly the frame, with the final sample still in flight
    always_comb begin
        scan_v   = '0;
        scan_max = '0;
        scan_min = '1;
        for (int i = 0; i < DEPTH; i++) begin
            scan_v   = (ADDR_W'(i) == wr_ptr_q) ? in_ad_data : buf_q[i];
            scan_max = (scan_v > scan_max) ? scan_v : scan_max;
            scan_min = (scan_v < scan_min) ? scan_v : scan_min;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_cnt_d  = dec_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        trig_ptr_d = trig_ptr_q;
        prev_d     = prev_q;
        auto_d     = auto_q;
        done_d     = 1'b0;
        mode_d     = mode_q;
        edge_d     = edge_q;
        dec_d      = dec_q;
        max_d      = max_q;
        min_d      = min_q;
        pk_d       = pk_q;
        if (enable && writing && stb)
            dec_cnt_d = (dec_cnt_q == dec_max) ? 8'd0 : dec_cnt_q + 8'd1;
        if (store) begin
            wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            prev_d   = in_ad_data;
        end
        case (state_q)
            IDLE: if (enable) state_d = PRE;
            PRE: if (store) begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q + 32'd1 == 32'(PRE_TRIG)) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: if (store) begin
                cnt_d = cnt_q + 32'd1;
                if (hit || force_trig) begin
                    state_d    = POST;
                    cnt_d      = '0;
                    trig_ptr_d = wr_ptr_q;
                    auto_d     = ~hit;
                end
            end
            POST: if (store) begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q + 32'd1 == 32'(DEPTH - PRE_TRIG - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            HOLD: if (mode_q == MODE_SINGLE ? arm : (arm || frame_ack)) state_d = PRE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
        if (state_d == PRE && state_q != PRE) begin
            wr_ptr_d  = '0;
            dec_cnt_d = '0;
            cnt_d     = '0;
            auto_d    = 1'b0;
            mode_d    = trig_mode;
            edge_d    = trig_edge;
            dec_d     = dec_ratio;
        end
        if (done_d) begin
            max_d = scan_max;
            min_d = scan_min;
            pk_d  = scan_max - scan_min;
        end
    end

    // Trigger-relative index folded into the circular buffer without a divider
    always_comb begin
        rd_base   = (trig_ptr_q >= ADDR_W'(PRE_TRIG)) ? trig_ptr_q - ADDR_W'(PRE_TRIG)
                                                     : trig_ptr_q + ADDR_W'(DEPTH - PRE_TRIG);
        rd_room   = (ADDR_W+1)'(DEPTH) - {1'b0, rd_base};
        rd_phys   = ({1'b0, rd_addr} < rd_room) ? rd_base + rd_addr : rd_addr - rd_room[ADDR_W-1:0];
        rd_data_d = (state_q == HOLD && state_d == HOLD && {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH))
                    ? buf_q[rd_phys] : '0;
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q    <= IDLE;
            ad_s1_q    <= 1'b0;
            ad_s2_q    <= 1'b0;
            ad_s3_q    <= 1'b0;
            cnt_q      <= '0;
            dec_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            trig_ptr_q <= '0;
            prev_q     <= '0;
            auto_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= '0;
            edge_q     <= 1'b0;
            dec_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            pk_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ad_s1_q    <= AD_CS;
            ad_s2_q    <= ad_s1_q;
            ad_s3_q    <= ad_s2_q;
            cnt_q      <= cnt_d;
            dec_cnt_q  <= dec_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_ptr_q <= trig_ptr_d;
            prev_q     <= prev_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            edge_q     <= edge_d;
            dec_q      <= dec_d;
            max_q      <= max_d;
            min_q      <= min_d;
            pk_q       <= pk_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (store) buf_q[wr_ptr_q] <= in_ad_data;
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = state_q == HOLD;
    assign frame_done  = done_q;
    assign auto_trig   = auto_q;
    assign samp_max    = max_q;
    assign samp_min    = min_q;
    assign pk_pk       = pk_q;
endmodule

// File: tb/tb_scope_trigger_capture.sv
// tb_scope_trigger_capture: randomized frames checked against a sample-list model
// of the capture rules (decimate, find trigger, slice the frame).
module tb_scope_trigger_capture;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int PRE   = 4;
    localparam int ATO   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ad_cs = 1'b0;
    logic [DW-1:0] in_ad_data = '0;
    logic          enable = 1'b0;
    logic [1:0]    trig_mode = '0;
    logic          trig_edge = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [7:0]    dec_ratio = 8'd1;
    logic          arm = 1'b0;
    logic          frame_ack = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data, samp_max, samp_min, pk_pk;
    logic          frame_valid, frame_done, auto_trig;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    logic [7:0] vals[$];
    logic [7:0] frame[DEPTH];
    bit         complete, exp_auto;
    int         n_str;

    scope_trigger_capture #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .PRE_TRIG(PRE), .AUTO_TO(ATO)) dut (
        .CLK_50M(clk), .RST(rst), .AD_CS(ad_cs), .in_ad_data(in_ad_data), .enable(enable),
        .trig_mode(trig_mode), .trig_edge(trig_edge), .trig_level(trig_level), .dec_ratio(dec_ratio),
        .arm(arm), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_valid(frame_valid), .frame_done(frame_done), .auto_trig(auto_trig),
        .samp_max(samp_max), .samp_min(samp_min), .pk_pk(pk_pk)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done) done_cnt++;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] v);
        in_ad_data = v;
        ad_cs = 1'b1;
        tick();
        tick();
        ad_cs = 1'b0;
        tick();
        tick();
    endtask

    // Frame = the DEPTH stored samples starting PRE before the trigger sample
    task automatic model(input logic [1:0] mode, input logic edg, input logic [7:0] lvl, input logic [7:0] dec);
        logic [7:0] st[$];
        int sidx[$];
        int d, trig;
        bit nat;
        d = (dec > 8'd1) ? int'(dec) : 1;
        trig = -1;
        complete = 1'b0;
        exp_auto = 1'b0;
        n_str = vals.size();
        for (int j = 0; j < vals.size(); j++)
            if (j % d == 0) begin
                st.push_back(vals[j]);
                sidx.push_back(j);
            end
        for (int k = PRE; k < st.size() && trig < 0; k++) begin
            nat = edg ? (st[k-1] > lvl && st[k] <= lvl) : (st[k-1] < lvl && st[k] >= lvl);
            if (nat || (mode == 2'b00 && k - PRE == ATO)) begin
                trig = k;
                exp_auto = !nat;
            end
        end
        if (trig >= 0 && trig + DEPTH - PRE - 1 < st.size()) begin
            complete = 1'b1;
            n_str = sidx[trig + DEPTH - PRE - 1] + 1;
            for (int i = 0; i < DEPTH; i++) frame[i] = st[trig - PRE + i];
        end
    endtask

    task automatic start_frame(input logic [1:0] mode, input logic edg, input logic [7:0] lvl, input logic [7:0] dec);
        enable = 1'b0;
        tick();
        tick();
        trig_mode = mode;
        trig_edge = edg;
        trig_level = lvl;
        dec_ratio = dec;
        enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            if (a > 0) check({tag, "_latency"}, 32'(rd_data), 32'(frame[a-1]));
            tick();
            check(tag, 32'(rd_data), 32'(frame[a]));
        end
    endtask

    task automatic run_frame(input logic [1:0] mode, input logic edg, input logic [7:0] lvl, input logic [7:0] dec);
        int d0;
        logic [7:0] mx, mn;
        start_frame(mode, edg, lvl, dec);
        model(mode, edg, lvl, dec);
        d0 = done_cnt;
        for (int j = 0; j < n_str; j++) begin
            if (complete && j == n_str - 1) check("early_valid", 32'(frame_valid), 32'd0);
            strobe(vals[j]);
        end
        for (int i = 0; i < 8 && frame_valid !== 1'b1; i++) tick();
        check("frame_valid", 32'(frame_valid), 32'(complete));
        if (complete) begin
            mx = 8'h00;
            mn = 8'hFF;
            for (int i = 0; i < DEPTH; i++) begin
                mx = (frame[i] > mx) ? frame[i] : mx;
                mn = (frame[i] < mn) ? frame[i] : mn;
            end
            check("auto_trig", 32'(auto_trig), 32'(exp_auto));
            check("samp_max", 32'(samp_max), 32'(mx));
            check("samp_min", 32'(samp_min), 32'(mn));
            check("pk_pk", 32'(pk_pk), 32'(mx) - 32'(mn));
            check("done_pulses", done_cnt - d0, 32'd1);
            read_all("rd");
            rd_addr = AW'(DEPTH + $urandom_range(0, DEPTH - 1));
            tick();
            check("rd_oob", 32'(rd_data), 32'd0);
        end else begin
            check("done_pulses_none", done_cnt - d0, 32'd0);
        end
    endtask

    task automatic leave_hold(input logic [1:0] mode);
        if (mode == 2'b10) begin
            frame_ack = 1'b1;
            tick();
            frame_ack = 1'b0;
            check("single_ack_valid", 32'(frame_valid), 32'd1);
            repeat (3) strobe(8'($urandom));
            check("single_strobe_valid", 32'(frame_valid), 32'd1);
            read_all("single_rd");
            arm = 1'b1;
            tick();
            arm = 1'b0;
            check("rearm_valid", 32'(frame_valid), 32'd0);
        end else begin
            frame_ack = 1'b1;
            tick();
            frame_ack = 1'b0;
            check("ack_valid", 32'(frame_valid), 32'd0);
        end
        check("left_rd_zero", 32'(rd_data), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_done"}, 32'(frame_done), 32'd0);
        check({tag, "_auto"}, 32'(auto_trig), 32'd0);
        check({tag, "_max"}, 32'(samp_max), 32'd0);
        check({tag, "_min"}, 32'(samp_min), 32'd0);
        check({tag, "_pk"}, 32'(pk_pk), 32'd0);
        check({tag, "_rd"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        logic [1:0] m;
        int d0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        vals.delete();
        for (int i = 0; i < 30; i++) vals.push_back(8'(8'h70 + 4 * i));
        run_frame(2'b01, 1'b0, 8'h80, 8'd1);
        check("ramp_pk", 32'(pk_pk), 32'h3C);
        rd_addr = 5'd4;
        tick();
        check("ramp_rd4", 32'(rd_data), 32'h80);
        rd_addr = 5'd0;
        tick();
        check("ramp_rd0", 32'(rd_data), 32'h70);
        leave_hold(2'b01);

        vals.delete();
        repeat (40) vals.push_back(8'h10);
        run_frame(2'b00, 1'b0, 8'h80, 8'd1);
        check("auto_flag", 32'(auto_trig), 32'd1);
        check("auto_min", 32'(samp_min), 32'h10);
        check("auto_pk", 32'(pk_pk), 32'd0);
        leave_hold(2'b00);

        vals.delete();
        repeat (80) vals.push_back(8'($urandom));
        run_frame(2'b10, 1'($urandom), 8'h80, 8'd1);
        if (complete) leave_hold(2'b10);

        vals.delete();
        for (int i = 0; i < 48; i++) vals.push_back(8'(i));
        run_frame(2'b01, 1'b0, 8'd12, 8'd3);
        rd_addr = 5'd5;
        tick();
        check("dec_rd5", 32'(rd_data), 32'd15);
        leave_hold(2'b01);

        for (int f = 0; f < 20; f++) begin
            vals.delete();
            repeat ($urandom_range(40, 120)) vals.push_back(8'($urandom));
            m = 2'($urandom);
            run_frame(m, 1'($urandom), 8'($urandom), 8'($urandom_range(0, 3)));
            if (complete) leave_hold(m);
        end

        vals.delete();
        for (int i = 0; i < 30; i++) vals.push_back(8'(8'h70 + 4 * i));
        start_frame(2'b01, 1'b0, 8'h80, 8'd1);
        d0 = done_cnt;
        for (int j = 0; j < 7; j++) strobe(vals[j]);
        enable = 1'b0;
        tick();
        check("en_drop_valid", 32'(frame_valid), 32'd0);
        for (int j = 7; j < 30; j++) strobe(vals[j]);
        check("en_drop_valid_late", 32'(frame_valid), 32'd0);
        check("en_drop_done", done_cnt - d0, 32'd0);

        start_frame(2'b01, 1'b0, 8'h80, 8'd1);
        d0 = done_cnt;
        for (int j = 0; j < 7; j++) strobe(vals[j]);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        for (int j = 7; j < 30; j++) strobe(vals[j]);
        check("midrst_valid_late", 32'(frame_valid), 32'd0);
        check("midrst_done", done_cnt - d0, 32'd0);

        run_frame(2'b01, 1'b0, 8'h80, 8'd1);
        leave_hold(2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
